// File: rtl/ili9341_parallel_8bit_rx_if.sv
// ILI9341 8080-style write bus plus framebuffer write port.
// The master drives the panel bus and observes framebuffer writes.
// The slave is the panel model: it receives the bus and produces framebuffer writes.
interface ili9341_parallel_8bit_rx_if #(
    parameter int ADDR_W = 17
);
    logic              tft_rst;
    logic              tft_cs;
    logic              tft_rs;
    logic              tft_wr;
    logic [7:0]        tft_data;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;

    modport master (
        output tft_rst, tft_cs, tft_rs, tft_wr, tft_data,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  tft_rst, tft_cs, tft_rs, tft_wr, tft_data,
        output fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/ili9341_parallel_8bit_rx.sv
// Panel-side model of the ILI9341 8-bit 8080 write bus.
// Decodes commands and parameters, tracks the column/page window and turns
// RGB565 byte pairs into framebuffer write strobes.
module ili9341_parallel_8bit_rx #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int ADDR_W      = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    ili9341_parallel_8bit_rx_if.slave bus,
    output logic                      cmd_strobe,
    output logic [7:0]                cmd_byte,
    output logic                      display_on,
    output logic                      sleep_out,
    output logic [7:0]                madctl,
    output logic [7:0]                pixfmt,
    output logic                      frame_done
);

    typedef enum logic [1:0] {IDLE, PARAM, MEMWR} state_t;

    localparam logic [15:0] H_LIM   = 16'(H_RES);
    localparam logic [15:0] V_LIM   = 16'(V_RES);
    localparam logic [15:0] EC_INIT = 16'(H_RES - 1);
    localparam logic [15:0] EP_INIT = 16'(V_RES - 1);
    // {tft_rst, cs, rs, wr, data} as seen when the bus is quiet
    localparam logic [11:0] BUS_IDLE = 12'b1101_0000_0000;

    logic [11:0] raw_bus;
    logic [11:0] s_bus;
    assign raw_bus = {bus.tft_rst, bus.tft_cs, bus.tft_rs, bus.tft_wr, bus.tft_data};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_bus = raw_bus;
        end else begin : g_sync
            logic [11:0] chain [SYNC_STAGES];
            // All bus lines share one chain so rs/data stay aligned with wr
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= BUS_IDLE;
                end else begin
                    chain[0] <= raw_bus;
                    for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
                end
            end
            assign s_bus = chain[SYNC_STAGES-1];
        end
    endgenerate

    logic       s_tft_rst, s_cs, s_rs, s_wr;
    logic [7:0] s_data;
    assign {s_tft_rst, s_cs, s_rs, s_wr, s_data} = s_bus;

    logic wr_prev;
    // Previous synced wr level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) wr_prev <= 1'b1;
        else     wr_prev <= s_wr;
    end

    logic hard_rst, accept, is_cmd, is_data;
    assign hard_rst = rst | ~s_tft_rst;
    assign accept   = s_wr & ~wr_prev & ~s_cs;
    assign is_cmd   = accept & ~s_rs;
    assign is_data  = accept & s_rs;

    state_t      state_q, state_d;
    logic [2:0]  param_left;
    logic [7:0]  param_cmd;
    logic [23:0] param_shift;
    logic        half;
    logic [7:0]  hi;
    logic [15:0] x, y, sc, ec, sp, ep;
    logic [31:0] pix_addr;
    logic        param_last;

    assign pix_addr   = 32'(y) * 32'(H_RES) + 32'(x);
    assign param_last = is_data && (state_q == PARAM) && (param_left == 3'd1);

    // State register
    always_ff @(posedge clk) begin
        if (hard_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: commands redirect from any state, last parameter returns to IDLE
    always_comb begin
        state_d = state_q;
        if (is_cmd) begin
            case (s_data)
                8'h2A, 8'h2B, 8'h36, 8'h3A: state_d = PARAM;
                8'h2C, 8'h3C:               state_d = MEMWR;
                default:                    state_d = IDLE;
            endcase
        end else if (param_last) begin
            state_d = IDLE;
        end
    end

    // Command decode, parameter commit, pixel assembly and window pointer
    always_ff @(posedge clk) begin
        if (hard_rst) begin
            cmd_strobe  <= 1'b0;
            cmd_byte    <= 8'h00;
            display_on  <= 1'b0;
            sleep_out   <= 1'b0;
            madctl      <= 8'h00;
            pixfmt      <= 8'h66;
            frame_done  <= 1'b0;
            bus.fb_we   <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_data <= 16'h0000;
            param_left  <= 3'd0;
            param_cmd   <= 8'h00;
            param_shift <= 24'h0;
            half        <= 1'b0;
            hi          <= 8'h00;
            x           <= 16'd0;
            y           <= 16'd0;
            sc          <= 16'd0;
            ec          <= EC_INIT;
            sp          <= 16'd0;
            ep          <= EP_INIT;
        end else begin
            cmd_strobe <= 1'b0;
            frame_done <= 1'b0;
            bus.fb_we  <= 1'b0;
            if (is_cmd) begin
                cmd_strobe <= 1'b1;
                cmd_byte   <= s_data;
                param_cmd  <= s_data;
                param_left <= 3'd0;
                half       <= 1'b0;
                case (s_data)
                    8'h01: begin
                        display_on  <= 1'b0;
                        sleep_out   <= 1'b0;
                        madctl      <= 8'h00;
                        pixfmt      <= 8'h66;
                        bus.fb_addr <= '0;
                        bus.fb_data <= 16'h0000;
                        x           <= 16'd0;
                        y           <= 16'd0;
                        sc          <= 16'd0;
                        ec          <= EC_INIT;
                        sp          <= 16'd0;
                        ep          <= EP_INIT;
                    end
                    8'h10: sleep_out  <= 1'b0;
                    8'h11: sleep_out  <= 1'b1;
                    8'h28: display_on <= 1'b0;
                    8'h29: display_on <= 1'b1;
                    8'h2A, 8'h2B: param_left <= 3'd4;
                    8'h36, 8'h3A: param_left <= 3'd1;
                    8'h2C: begin
                        x <= sc;
                        y <= sp;
                    end
                    default: ;
                endcase
            end else if (is_data && state_q == PARAM) begin
                param_shift <= {param_shift[15:0], s_data};
                param_left  <= param_left - 3'd1;
                if (param_left == 3'd1) begin
                    case (param_cmd)
                        8'h2A: begin
                            sc <= param_shift[23:8];
                            ec <= {param_shift[7:0], s_data};
                        end
                        8'h2B: begin
                            sp <= param_shift[23:8];
                            ep <= {param_shift[7:0], s_data};
                        end
                        8'h36:   madctl <= s_data;
                        8'h3A:   pixfmt <= s_data;
                        default: ;
                    endcase
                end
            end else if (is_data && state_q == MEMWR) begin
                if (!half) begin
                    hi   <= s_data;
                    half <= 1'b1;
                end else begin
                    half <= 1'b0;
                    if (x < H_LIM && y < V_LIM) begin
                        bus.fb_we   <= 1'b1;
                        bus.fb_addr <= pix_addr[ADDR_W-1:0];
                        bus.fb_data <= {hi, s_data};
                    end
                    if (x >= ec) begin
                        x <= sc;
                        if (y >= ep) begin
                            y          <= sp;
                            frame_done <= 1'b1;
                        end else begin
                            y <= y + 16'd1;
                        end
                    end else begin
                        x <= x + 16'd1;
                    end
                end
            end
        end
    end

endmodule
